// File: rtl/seg7_operand_decoder.sv
// Receive-side decoder: collects DIGITS active-low 7-segment glyphs (LSB first) into an operand.
// Define SEG7_STRICT_CHECK_EN to flag invalid glyphs on frame_err; otherwise frame_err is tied low.
module seg7_operand_decoder #(
  parameter int DIGITS  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [6:0]        seg_code,
  output logic              in_ready,
  output logic [DIGITS-1:0] operand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              timeout
);

  localparam int         IDXW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] GLYPH_ONE = 7'b1111001;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx;
  logic [15:0]       idle_cnt;
  logic              accept;
  logic              glyph_bit;
  logic              last_glyph;

  assign glyph_bit  = (seg_code == GLYPH_ONE);
  assign in_ready   = (state != DONE);
  assign out_valid  = (state == DONE);
  assign last_glyph = (idx == IDXW'(DIGITS - 1));

  // The abort cycle wins over a glyph offered on the same edge; the sender simply holds it.
  assign timeout = (state == COLLECT) && (idle_cnt == 16'(TIMEOUT));
  assign accept  = in_valid && in_ready && !timeout;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = last_glyph ? DONE : COLLECT;
      end
      COLLECT: begin
        if (timeout)                   state_nxt = IDLE;
        else if (accept && last_glyph) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      idle_cnt <= '0;
      operand  <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        if (state == IDLE) operand <= DIGITS'(glyph_bit);
        else               operand[idx] <= glyph_bit;
        idx <= last_glyph ? '0 : idx + 1'b1;
      end else if (timeout) begin
        idx <= '0;
      end

      if (state == COLLECT && !accept && !timeout) idle_cnt <= idle_cnt + 16'd1;
      else                                         idle_cnt <= '0;
    end
  end

`ifdef SEG7_STRICT_CHECK_EN
  localparam logic [6:0] GLYPH_ZERO = 7'b1000000;

  logic glyph_bad;
  logic err_q;

  assign glyph_bad = (seg_code != GLYPH_ZERO) && (seg_code != GLYPH_ONE);
  assign frame_err = err_q;

  // The first glyph of a frame restarts the sticky error; an aborted frame leaves no error behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= (state == IDLE) ? glyph_bad : (err_q | glyph_bad);
    end else if (timeout) begin
      err_q <= 1'b0;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_operand_decoder.sv
// Directed bench for seg7_operand_decoder (DIGITS=6, TIMEOUT=4): vector table plus timeout and reset sequences.
module tb_seg7_operand_decoder;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] GB = 7'b0000000;
  localparam logic [6:0] GJ = 7'b0110000;
`ifdef SEG7_STRICT_CHECK_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  typedef struct {
    logic [41:0] glyphs;
    int          stall;
    logic [5:0]  exp_op;
    logic        exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [6:0] seg_code = G0;
  logic       in_ready;
  logic [5:0] operand;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       frame_err;
  logic       timeout;

  int num_tests  = 0;
  int num_failed = 0;
  vec_t vecs [7];

  seg7_operand_decoder #(.DIGITS(6), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .seg_code  (seg_code),
    .in_ready  (in_ready),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    num_tests++;
    if (actual !== expected) begin
      num_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic sendGlyphs(input logic [41:0] glyphs, input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      seg_code = glyphs[i*7 +: 7];
      checkOutput("in_ready_before_glyph", 16'(in_ready), 16'd1);
      checkOutput("out_valid_mid_frame", 16'(out_valid), 16'd0);
      @(posedge clk);
    end
  endtask

  // Sends one full frame, holds out_ready low for v.stall cycles, then checks the release.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    out_ready = (v.stall == 0);
    sendGlyphs(v.glyphs, 6);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("out_valid_done", 16'(out_valid), 16'd1);
    checkOutput("in_ready_done", 16'(in_ready), 16'd0);
    checkOutput("operand_done", 16'(operand), 16'(v.exp_op));
    checkOutput("frame_err_done", 16'(frame_err), 16'(v.exp_err));
    for (int s = 0; s < v.stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("out_valid_stall", 16'(out_valid), 16'd1);
      checkOutput("in_ready_stall", 16'(in_ready), 16'd0);
      checkOutput("operand_stall", 16'(operand), 16'(v.exp_op));
      checkOutput("frame_err_stall", 16'(frame_err), 16'(v.exp_err));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("out_valid_release", 16'(out_valid), 16'd0);
    checkOutput("in_ready_release", 16'(in_ready), 16'd1);
    checkOutput("operand_hold", 16'(operand), 16'(v.exp_op));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{glyphs: {G0, G1, G0, G1, G0, G0}, stall: 0, exp_op: 6'b010100, exp_err: 1'b0};
    vecs[1] = '{glyphs: {G0, G1, G0, G1, G0, G0}, stall: 5, exp_op: 6'b010100, exp_err: 1'b0};
    vecs[2] = '{glyphs: {G1, G1, GB, G1, G0, G1}, stall: 0, exp_op: 6'b110101, exp_err: STRICT};
    vecs[3] = '{glyphs: {G1, G0, G1, G0, G1, G0}, stall: 1, exp_op: 6'b101010, exp_err: 1'b0};
    vecs[4] = '{glyphs: {G1, G1, G1, G1, G1, G1}, stall: 0, exp_op: 6'b111111, exp_err: 1'b0};
    vecs[5] = '{glyphs: {G0, G0, G0, G0, G0, GJ}, stall: 2, exp_op: 6'b000000, exp_err: STRICT};
    vecs[6] = '{glyphs: {G0, G0, G0, G0, G0, G1}, stall: 0, exp_op: 6'b000001, exp_err: 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_in_ready", 16'(in_ready), 16'd1);
    checkOutput("reset_out_valid", 16'(out_valid), 16'd0);
    checkOutput("reset_operand", 16'(operand), 16'd0);
    checkOutput("reset_frame_err", 16'(frame_err), 16'd0);
    checkOutput("reset_timeout", 16'(timeout), 16'd0);

    for (int n = 0; n < 7; n++) applyStimulus(vecs[n]);

    // Partial frame of three ones, then silence: abort pulse lands 4 cycles after the third accept.
    sendGlyphs({G0, G0, G0, G1, G1, G1}, 3);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("timeout_after_accept", 16'(timeout), 16'd0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("timeout_cycle%0d", c), 16'(timeout), 16'(c == 4));
    end
    checkOutput("timeout_in_ready", 16'(in_ready), 16'd1);
    checkOutput("timeout_out_valid", 16'(out_valid), 16'd0);
    checkOutput("timeout_operand_kept", 16'(operand), 16'b000111);
    checkOutput("timeout_frame_err", 16'(frame_err), 16'd0);
    applyStimulus(vecs[4]);

    // Reset after four glyphs: everything back to reset values, and no late abort pulse.
    sendGlyphs({G1, G1, G1, G1, G1, G1}, 4);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_in_ready", 16'(in_ready), 16'd1);
    checkOutput("midreset_out_valid", 16'(out_valid), 16'd0);
    checkOutput("midreset_operand", 16'(operand), 16'd0);
    checkOutput("midreset_frame_err", 16'(frame_err), 16'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("midreset_no_timeout", 16'(timeout), 16'd0);
    end
    applyStimulus(vecs[6]);

    $display("[TB] %0d tests run, %0d failed", num_tests, num_failed);
    $finish;
  end

endmodule

// File: doc/seg7_operand_decoder.md
# seg7_operand_decoder

Receive-side decoder for the ALU operand display path. It accepts the six 7-segment glyphs that represent a 6-bit operand, one glyph per handshake, least-significant display first. It decodes each glyph back to a bit, assembles the operand, and presents it with a valid/ready handshake and a glyph-error flag. It sits opposite the operand-to-display encoder and is used to close the loop in board self-check and in benches.

## Interface
Parameters:
- `DIGITS`, default 6: glyphs per frame, which is also the operand width.
- `TIMEOUT`, default 255: maximum number of idle cycles allowed between glyphs inside a frame. Legal range is 1..65535.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: `seg_code` carries a glyph.
- `seg_code` input 7: active-low glyph, bit0 = segment a ... bit6 = segment g.
- `in_ready` output 1: the decoder can accept a glyph.
- `operand` output `DIGITS`: assembled value; bit i comes from glyph i.
- `out_valid` output 1: `operand` and `frame_err` are valid.
- `out_ready` input 1: the consumer accepts the frame.
- `frame_err` output 1: at least one glyph in the frame was invalid.
- `timeout` output 1: one-cycle pulse when a partial frame is aborted.

## Operation
Glyph decode (active-low):
- 7'b1000000 is "0" and decodes to bit 0.
- 7'b1111001 is "1" and decodes to bit 1.
- Any other code is invalid. See Configuration for how invalid codes decode.

State machine:
- IDLE: no glyph of the current frame has been accepted yet. `in_ready` = 1.
- COLLECT: 1 to `DIGITS`-1 glyphs have been accepted. `in_ready` = 1.
- DONE: the frame is complete. `in_ready` = 0, `out_valid` = 1.

Transitions:
- A glyph is accepted when `in_valid` and `in_ready` are both 1 on a rising edge.
- Acceptance writes the decoded bit into `operand[idx]`, increments `idx`, and ORs the glyph's invalid flag into `frame_err`.
- The first accept in IDLE clears `operand`, clears `frame_err`, writes bit 0, and moves to COLLECT. When `DIGITS` = 1 it moves to DONE instead.
- The accept that fills bit `DIGITS`-1 moves to DONE.
- In DONE, `out_valid` and `out_ready` both high returns to IDLE on the same edge. `operand` holds its value. `out_valid` drops the following cycle.
- While stalled in DONE, `operand` and `frame_err` hold stable.

Idle counter:
- Active only in COLLECT. It clears on every accept and increments on every cycle with no accept.
- When the counter reaches `TIMEOUT`, the partial frame is discarded: `idx` clears, state returns to IDLE, and `timeout` pulses for one cycle. `operand` keeps its old contents and `frame_err` is cleared.

Reset:
- Reset in any state forces IDLE on that edge, even mid-frame. The partial frame is lost and no `timeout` pulse is generated.
- `reset` has priority over every other input.

## Timing
Reset values:
- `operand` = 0
- `out_valid` = 0
- `frame_err` = 0
- `timeout` = 0
- `in_ready` = 1
- `idx` = 0
- idle counter = 0

Cycle behaviour:
- Back-to-back glyphs are accepted at one per cycle. `out_valid` rises on the cycle after the edge that accepts the last glyph.
- Best-case frame latency is `DIGITS` accept edges, then `out_valid` is high on the next cycle.
- Frame throughput is `DIGITS`+1 cycles when `out_ready` is held high. `in_ready` is low during the DONE cycle.
- `in_ready` is a registered function of state only. It has no combinational path from `out_ready`.
- Timeout: after the last accept, `TIMEOUT` consecutive non-accept cycles raise `timeout` in the cycle that follows. `in_valid` asserted on that same edge is not accepted, because the frame is being aborted. Nothing is lost, since the sender holds a glyph until it is accepted.

## Configuration
Macro `SEG7_STRICT_CHECK_EN`:
- Defined: an invalid glyph decodes to bit 0 and sets `frame_err` for that frame.
- Undefined: glyphs are not checked. Any code other than 7'b1111001 decodes to 0, `frame_err` is tied to 0, and no check logic is synthesized.
- State machine, handshakes and timeout are identical in both builds.

## Test plan
1. Value 6'b010100, back-to-back: send glyphs 1000000, 1000000, 1111001, 1000000, 1111001, 1000000 with `out_ready`=1 -> `out_valid`=1 for one cycle on cycle 7, `operand`=6'b010100, `frame_err`=0.
2. Backpressure: same frame with `out_ready`=0 for 5 cycles -> `out_valid` held, `operand` stable, `in_ready`=0 throughout. When `out_ready` rises -> IDLE next cycle and `in_ready`=1.
3. Bad glyph (strict build): glyph 3 = 7'b0000000 in frame 1,0,1,0,1,1 (idx order) -> bit 3 = 0, `frame_err`=1. The next clean frame clears `frame_err`.
4. Timeout: `TIMEOUT`=4, send 3 glyphs then hold `in_valid`=0 -> `timeout` pulses exactly once, 4 cycles after the third accept, state returns to IDLE. A following full frame of value 6'b111111 decodes correctly.
5. Reset mid-frame: `reset` asserted after 4 glyphs -> all outputs at reset values, no `timeout` pulse. The next full frame of value 6'b000001 yields `operand`=6'b000001.
6. All-ones frame 6'b111111 -> `operand`=6'b111111. In the non-strict build, glyph 7'b0000000 -> bit 0 and `frame_err`=0.
